// File: rtl/final_soc_onchip_mem_arbiter.sv
// Round-robin arbiter letting two Avalon-MM masters share one single-port RAM
// with a registered address and a fixed read latency.
module final_soc_onchip_mem_arbiter #(
  parameter int ADDR_W       = 2,
  parameter int DATA_W       = 32,
  parameter int BE_W         = 4,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  output logic              mem_reset_req,
  input  logic [DATA_W-1:0] mem_readdata,
  output logic [1:0]        dbg_state_o,
  output logic              dbg_rr_ptr_o
);

  // Encoding is visible on dbg_state_o: 0 IDLE, 1 ISSUE, 2 RWAIT, 3 RRET.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RWAIT = 2'd2,
    S_RRET  = 2'd3
  } state_t;

  localparam logic [1:0] CNT_INIT = 2'(READ_LATENCY - 1);

  state_t            state_q, state_d;
  logic              rr_q, rr_d;
  logic              gnt_q, gnt_d;
  logic              op_wr_q, op_wr_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;

  logic req0, req1, pick1;

  // Handshake: a master holds read/write until it sees waitrequest low; that
  // single cycle is acceptance. readdatavalid is a one-cycle strobe that
  // qualifies readdata, which otherwise holds its last value.
  assign req0  = m0_read | m0_write;
  assign req1  = m1_read | m1_write;
  assign pick1 = req1 & (~req0 | rr_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      rr_q     <= 1'b0;
      gnt_q    <= 1'b0;
      op_wr_q  <= 1'b0;
      cnt_q    <= '0;
      addr_q   <= '0;
      be_q     <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      gnt_q    <= gnt_d;
      op_wr_q  <= op_wr_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    gnt_d    = gnt_q;
    op_wr_d  = op_wr_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    case (state_q)
      S_IDLE: begin
        if (req0 | req1) begin
          // The whole command is latched here; later input changes are ignored.
          gnt_d   = pick1;
          rr_d    = ~pick1;
          addr_d  = pick1 ? m1_address    : m0_address;
          be_d    = pick1 ? m1_byteenable : m0_byteenable;
          wdata_d = pick1 ? m1_writedata  : m0_writedata;
          op_wr_d = pick1 ? m1_write      : m0_write;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (op_wr_q) begin
          state_d = S_IDLE;
        end else begin
          cnt_d   = CNT_INIT;
          state_d = S_RWAIT;
        end
      end
      S_RWAIT: begin
        if (cnt_q == 2'd0) begin
          if (gnt_q) rdata1_d = mem_readdata;
          else       rdata0_d = mem_readdata;
          state_d = S_RRET;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      S_RRET:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Strobes are gated by reset so nothing is accepted or returned while it is high.
  always_comb begin
    mem_chipselect   = 1'b0;
    mem_write        = 1'b0;
    m0_waitrequest   = 1'b1;
    m1_waitrequest   = 1'b1;
    m0_readdatavalid = 1'b0;
    m1_readdatavalid = 1'b0;
    if (!reset) begin
      if (state_q == S_ISSUE) begin
        mem_chipselect = 1'b1;
        mem_write      = op_wr_q;
        m0_waitrequest = gnt_q;
        m1_waitrequest = ~gnt_q;
      end
      if (state_q == S_RRET) begin
        m0_readdatavalid = ~gnt_q;
        m1_readdatavalid = gnt_q;
      end
    end
  end

  assign mem_address    = addr_q;
  assign mem_byteenable = be_q;
  assign mem_writedata  = wdata_q;
  assign mem_clken      = 1'b1;
  assign mem_reset_req  = reset;
  assign m0_readdata    = rdata0_q;
  assign m1_readdata    = rdata1_q;
  assign dbg_state_o    = state_q;
  assign dbg_rr_ptr_o   = rr_q;

endmodule

// File: tb/tb_final_soc_onchip_mem_arbiter.sv
// Bench for the two-master RAM arbiter: instance 0 has read latency 1,
// instance 1 has read latency 2; each has its own behavioural RAM.
module tb_final_soc_onchip_mem_arbiter;

  localparam int ST_I = 0, ST_S = 1, ST_W = 2, ST_R = 3;
  localparam int DB  = 32'hDEADBEEF;
  localparam int BBD = 32'h11BB33DD;
  localparam int CF  = 32'hCAFEF00D;
  localparam int NV  = 36;

  logic        clk;
  logic        rst       [2];
  logic [1:0]  m_addr    [2][2];
  logic [3:0]  m_be      [2][2];
  logic        m_rd      [2][2];
  logic        m_wr      [2][2];
  logic [31:0] m_wd      [2][2];
  logic        m_wait    [2][2];
  logic        m_rdv     [2][2];
  logic [31:0] m_rdata   [2][2];
  logic [1:0]  mem_addr  [2];
  logic [3:0]  mem_be    [2];
  logic        mem_cs    [2];
  logic        mem_we    [2];
  logic        mem_clken [2];
  logic        mem_rreq  [2];
  logic [31:0] mem_wd    [2];
  logic [31:0] mem_rd    [2];
  logic [1:0]  dbg_st    [2];
  logic        dbg_rr    [2];

  int n_cmp;
  int n_fail;
  logic [0:0] exp_q[$];

  typedef struct {
    int rst;
    int rd0, wr0, a0, be0, wd0;
    int rd1, wr1, a1, be1, wd1;
    int st, w0, w1, v0, v1, d0, d1;
  } vec_t;
  vec_t vecs[NV];

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUTs and RAM models ----------------
  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [31:0] ram [4];
    logic [1:0]  ra_q;
    logic [31:0] q_pipe;

    final_soc_onchip_mem_arbiter #(
      .ADDR_W(2), .DATA_W(32), .BE_W(4), .READ_LATENCY(g + 1)
    ) u_dut (
      .clk              (clk),
      .reset            (rst[g]),
      .m0_address       (m_addr[g][0]),
      .m0_byteenable    (m_be[g][0]),
      .m0_read          (m_rd[g][0]),
      .m0_write         (m_wr[g][0]),
      .m0_writedata     (m_wd[g][0]),
      .m0_waitrequest   (m_wait[g][0]),
      .m0_readdata      (m_rdata[g][0]),
      .m0_readdatavalid (m_rdv[g][0]),
      .m1_address       (m_addr[g][1]),
      .m1_byteenable    (m_be[g][1]),
      .m1_read          (m_rd[g][1]),
      .m1_write         (m_wr[g][1]),
      .m1_writedata     (m_wd[g][1]),
      .m1_waitrequest   (m_wait[g][1]),
      .m1_readdata      (m_rdata[g][1]),
      .m1_readdatavalid (m_rdv[g][1]),
      .mem_address      (mem_addr[g]),
      .mem_byteenable   (mem_be[g]),
      .mem_chipselect   (mem_cs[g]),
      .mem_write        (mem_we[g]),
      .mem_writedata    (mem_wd[g]),
      .mem_clken        (mem_clken[g]),
      .mem_reset_req    (mem_rreq[g]),
      .mem_readdata     (mem_rd[g]),
      .dbg_state_o      (dbg_st[g]),
      .dbg_rr_ptr_o     (dbg_rr[g])
    );

    always @(posedge clk) begin
      if (mem_clken[g]) begin
        ra_q   <= mem_addr[g];
        q_pipe <= ram[ra_q];
        if (mem_cs[g] && mem_we[g])
          for (int b = 0; b < 4; b++)
            if (mem_be[g][b]) ram[mem_addr[g]][8*b +: 8] <= mem_wd[g][8*b +: 8];
      end
    end

    assign mem_rd[g] = (g == 0) ? ram[ra_q] : q_pipe;
  end

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // All driver tasks are entered and left 1 time unit after a rising edge.
  task automatic do_write(input int d, input int m, input logic [1:0] a,
                          input logic [31:0] wd, input logic [3:0] be);
    int   cyc;
    logic acc;
    m_wr[d][m] = 1'b1; m_addr[d][m] = a; m_wd[d][m] = wd; m_be[d][m] = be;
    cyc = 0; acc = 1'b0;
    while (!acc && cyc < 40) begin
      @(negedge clk);
      if (!m_wait[d][m]) acc = 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    m_wr[d][m] = 1'b0;
    chk("write_accept", 32'(acc), 32'd1);
  endtask

  task automatic do_read(input int d, input int m, input logic [1:0] a,
                         input logic [31:0] exp, input int lat);
    int   cyc;
    logic acc, got;
    m_rd[d][m] = 1'b1; m_addr[d][m] = a;
    cyc = 0; acc = 1'b0; got = 1'b0;
    while (!got && cyc < 40) begin
      @(negedge clk);
      if (m_rdv[d][m]) begin
        got = 1'b1;
        chk("rd_data", m_rdata[d][m], exp);
        chk("rd_latency", 32'(cyc), 32'(lat));
      end
      chk("rd_other_valid", 32'(m_rdv[d][1-m]), 32'd0);
      if (!m_wait[d][m]) acc = 1'b1;
      @(posedge clk); #1;
      if (acc) m_rd[d][m] = 1'b0;
      cyc++;
    end
    m_rd[d][m] = 1'b0;
    chk("rd_done", 32'(got), 32'd1);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // ---------------- main test ----------------
  initial begin
    int n0, n1, cyc;
    logic [0:0] g;
    n_cmp = 0; n_fail = 0;

    //            rst  rd0 wr0 a0 be0  wd0            rd1 wr1 a1 be1  wd1            st   w0 w1 v0 v1 d0  d1
    vecs[0]  = '{0,   0, 1, 2, 'hF, DB,            0, 0, 0, 0,   0,             ST_I, 1, 1, 0, 0, 0,  0};
    vecs[1]  = '{0,   0, 1, 2, 'hF, DB,            0, 0, 0, 0,   0,             ST_S, 0, 1, 0, 0, 0,  0};
    vecs[2]  = '{0,   1, 0, 2, 0,   0,             0, 0, 0, 0,   0,             ST_I, 1, 1, 0, 0, 0,  0};
    vecs[3]  = '{0,   1, 0, 2, 0,   0,             0, 0, 0, 0,   0,             ST_S, 0, 1, 0, 0, 0,  0};
    vecs[4]  = '{0,   0, 0, 0, 0,   0,             0, 0, 0, 0,   0,             ST_W, 1, 1, 0, 0, 0,  0};
    vecs[5]  = '{0,   0, 0, 0, 0,   0,             0, 0, 0, 0,   0,             ST_R, 1, 1, 1, 0, DB, 0};
    vecs[6]  = '{1,   0, 0, 0, 0,   0,             0, 0, 0, 0,   0,             ST_I, 1, 1, 0, 0, DB, 0};
    vecs[7]  = '{0,   1, 0, 2, 0,   0,             1, 0, 2, 0,   0,             ST_I, 1, 1, 0, 0, 0,  0};
    vecs[8]  = '{0,   1, 0, 2, 0,   0,             1, 0, 2, 0,   0,             ST_S, 0, 1, 0, 0, 0,  0};
    vecs[9]  = '{0,   0, 0, 0, 0,   0,             1, 0, 2, 0,   0,             ST_W, 1, 1, 0, 0, 0,  0};
    vecs[10] = '{0,   0, 0, 0, 0,   0,             1, 0, 2, 0,   0,             ST_R, 1, 1, 1, 0, DB, 0};
    vecs[11] = '{0,   0, 0, 0, 0,   0,             1, 0, 2, 0,   0,             ST_I, 1, 1, 0, 0, DB, 0};
    vecs[12] = '{0,   0, 0, 0, 0,   0,             1, 0, 2, 0,   0,             ST_S, 1, 0, 0, 0, DB, 0};
    vecs[13] = '{0,   0, 0, 0, 0,   0,             0, 0, 0, 0,   0,             ST_W, 1, 1, 0, 0, DB, 0};
    vecs[14] = '{0,   0, 0, 0, 0,   0,             0, 0, 0, 0,   0,             ST_R, 1, 1, 0, 1, DB, DB};
    vecs[15] = '{0,   0, 0, 0, 0,   0,             0, 1, 3, 'hF, 'h11223344,  ST_I, 1, 1, 0, 0, DB, DB};
    vecs[16] = '{0,   0, 0, 0, 0,   0,             0, 1, 3, 'hF, 'h11223344,  ST_S, 1, 0, 0, 0, DB, DB};
    vecs[17] = '{0,   0, 0, 0, 0,   0,             0, 1, 3, 'h5, 'hAABBCCDD,  ST_I, 1, 1, 0, 0, DB, DB};
    vecs[18] = '{0,   0, 0, 0, 0,   0,             0, 1, 3, 'h5, 'hAABBCCDD,  ST_S, 1, 0, 0, 0, DB, DB};
    vecs[19] = '{0,   0, 0, 0, 0,   0,             1, 0, 3, 0,   0,             ST_I, 1, 1, 0, 0, DB, DB};
    vecs[20] = '{0,   0, 0, 0, 0,   0,             1, 0, 3, 0,   0,             ST_S, 1, 0, 0, 0, DB, DB};
    vecs[21] = '{0,   0, 0, 0, 0,   0,             0, 0, 0, 0,   0,             ST_W, 1, 1, 0, 0, DB, DB};
    vecs[22] = '{0,   0, 0, 0, 0,   0,             0, 0, 0, 0,   0,             ST_R, 1, 1, 0, 1, DB, BBD};
    vecs[23] = '{0,   1, 1, 1, 'hF, CF,            0, 0, 0, 0,   0,             ST_I, 1, 1, 0, 0, DB, BBD};
    vecs[24] = '{0,   0, 0, 0, 0,   0,             0, 0, 0, 0,   0,             ST_S, 0, 1, 0, 0, DB, BBD};
    vecs[25] = '{0,   0, 0, 0, 0,   0,             0, 0, 0, 0,   0,             ST_I, 1, 1, 0, 0, DB, BBD};
    vecs[26] = '{0,   1, 0, 1, 0,   0,             0, 0, 0, 0,   0,             ST_I, 1, 1, 0, 0, DB, BBD};
    vecs[27] = '{0,   1, 0, 1, 0,   0,             0, 0, 0, 0,   0,             ST_S, 0, 1, 0, 0, DB, BBD};
    vecs[28] = '{0,   0, 0, 0, 0,   0,             0, 0, 0, 0,   0,             ST_W, 1, 1, 0, 0, DB, BBD};
    vecs[29] = '{0,   0, 0, 0, 0,   0,             0, 0, 0, 0,   0,             ST_R, 1, 1, 1, 0, CF, BBD};
    vecs[30] = '{0,   0, 1, 1, 0,   'hFFFFFFFF,    0, 0, 0, 0,   0,             ST_I, 1, 1, 0, 0, CF, BBD};
    vecs[31] = '{0,   0, 1, 1, 0,   'hFFFFFFFF,    0, 0, 0, 0,   0,             ST_S, 0, 1, 0, 0, CF, BBD};
    vecs[32] = '{0,   1, 0, 1, 0,   0,             0, 0, 0, 0,   0,             ST_I, 1, 1, 0, 0, CF, BBD};
    vecs[33] = '{0,   1, 0, 1, 0,   0,             0, 0, 0, 0,   0,             ST_S, 0, 1, 0, 0, CF, BBD};
    vecs[34] = '{0,   0, 0, 0, 0,   0,             0, 0, 0, 0,   0,             ST_W, 1, 1, 0, 0, CF, BBD};
    vecs[35] = '{0,   0, 0, 0, 0,   0,             0, 0, 0, 0,   0,             ST_R, 1, 1, 1, 0, CF, BBD};

    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1;
      for (int m = 0; m < 2; m++) begin
        m_rd[d][m] = 1'b0; m_wr[d][m] = 1'b0; m_addr[d][m] = '0;
        m_be[d][m] = '0;   m_wd[d][m] = '0;
      end
    end
    repeat (3) @(posedge clk);
    #1;
    rst[1] = 1'b0;
    @(negedge clk);
    chk("rst_mem_reset_req", 32'(mem_rreq[0]), 32'd1);
    chk("rst_clken", 32'(mem_clken[0]), 32'd1);
    chk("rst_chipselect", 32'(mem_cs[0]), 32'd0);
    chk("rst_rr_ptr", 32'(dbg_rr[0]), 32'd0);

    // Cycle-accurate vectors on instance 0: write/read, simultaneous reads,
    // byte lanes, read+write together, withdrawn request, byteenable zero.
    for (int i = 0; i < NV; i++) begin
      @(posedge clk); #1;
      rst[0]         = vecs[i].rst[0];
      m_rd[0][0]     = vecs[i].rd0[0];
      m_wr[0][0]     = vecs[i].wr0[0];
      m_addr[0][0]   = vecs[i].a0[1:0];
      m_be[0][0]     = vecs[i].be0[3:0];
      m_wd[0][0]     = vecs[i].wd0;
      m_rd[0][1]     = vecs[i].rd1[0];
      m_wr[0][1]     = vecs[i].wr1[0];
      m_addr[0][1]   = vecs[i].a1[1:0];
      m_be[0][1]     = vecs[i].be1[3:0];
      m_wd[0][1]     = vecs[i].wd1;
      @(negedge clk);
      chk($sformatf("v%0d_state", i), 32'(dbg_st[0]), vecs[i].st);
      chk($sformatf("v%0d_wait0", i), 32'(m_wait[0][0]), vecs[i].w0);
      chk($sformatf("v%0d_wait1", i), 32'(m_wait[0][1]), vecs[i].w1);
      chk($sformatf("v%0d_rdv0", i), 32'(m_rdv[0][0]), vecs[i].v0);
      chk($sformatf("v%0d_rdv1", i), 32'(m_rdv[0][1]), vecs[i].v1);
      chk($sformatf("v%0d_rdata0", i), m_rdata[0][0], vecs[i].d0);
      chk($sformatf("v%0d_rdata1", i), m_rdata[0][1], vecs[i].d1);
      chk($sformatf("v%0d_cs", i), 32'(mem_cs[0]), 32'(vecs[i].st == ST_S));
      chk($sformatf("v%0d_rstreq", i), 32'(mem_rreq[0]), vecs[i].rst);
    end

    // Back-to-back writes from both masters after a fresh reset.
    @(posedge clk); #1;
    rst[0] = 1'b1;
    for (int m = 0; m < 2; m++) begin m_rd[0][m] = 1'b0; m_wr[0][m] = 1'b0; end
    @(posedge clk); #1;
    rst[0] = 1'b0;
    for (int k = 0; k < 6; k++) begin exp_q.push_back(1'b0); exp_q.push_back(1'b1); end
    n0 = 0; n1 = 0; cyc = 0;
    while ((n0 < 6 || n1 < 6) && cyc < 100) begin
      m_wr[0][0] = (n0 < 6); m_addr[0][0] = 2'd0; m_be[0][0] = 4'hF; m_wd[0][0] = 32'h1000_0000 + 32'(n0);
      m_wr[0][1] = (n1 < 6); m_addr[0][1] = 2'd1; m_be[0][1] = 4'hF; m_wd[0][1] = 32'h2000_0000 + 32'(n1);
      @(negedge clk);
      chk("single_grant", 32'(!m_wait[0][0] && !m_wait[0][1]), 32'd0);
      for (int m = 0; m < 2; m++) begin
        if (!m_wait[0][m]) begin
          if (exp_q.size() > 0) begin
            g = exp_q.pop_front();
            chk("grant_order", 32'(m), 32'(g));
          end else begin
            chk("grant_extra", 32'(m), 32'hFFFF_FFFF);
          end
          if (m == 0) n0++; else n1++;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    m_wr[0][0] = 1'b0; m_wr[0][1] = 1'b0;
    chk("burst_in_budget", 32'(cyc < 100), 32'd1);
    chk("burst_cycles", 32'(cyc), 32'd24);
    do_read(0, 0, 2'd0, 32'h1000_0005, 3);
    do_read(0, 1, 2'd1, 32'h2000_0005, 3);

    // Reset during RWAIT on the latency-2 instance aborts the read.
    do_write(1, 1, 2'd3, 32'h5A5A_1234, 4'hF);
    do_read(1, 1, 2'd3, 32'h5A5A_1234, 4);
    m_rd[1][0] = 1'b1; m_addr[1][0] = 2'd3;
    @(negedge clk);
    chk("abort_idle", 32'(dbg_st[1]), ST_I);
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_issue", 32'(dbg_st[1]), ST_S);
    chk("abort_accept", 32'(m_wait[1][0]), 32'd0);
    @(posedge clk); #1;
    m_rd[1][0] = 1'b0;
    rst[1] = 1'b1;
    @(negedge clk);
    chk("abort_rwait", 32'(dbg_st[1]), ST_W);
    chk("abort_rstreq", 32'(mem_rreq[1]), 32'd1);
    @(posedge clk); #1;
    rst[1] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("abort_state", 32'(dbg_st[1]), ST_I);
      chk("abort_no_rdv", 32'(m_rdv[1][0]), 32'd0);
      chk("abort_wait0", 32'(m_wait[1][0]), 32'd1);
      chk("abort_wait1", 32'(m_wait[1][1]), 32'd1);
      chk("abort_rdata0", m_rdata[1][0], 32'd0);
      @(posedge clk); #1;
    end
    do_read(1, 1, 2'd3, 32'h5A5A_1234, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
